// File: rtl/inv_round_if.sv
// inv_round_if: handshake bundle between an AES inverse-round producer and consumer
// Signals: in_valid/in_ready/state_in/round_key/last_round (input side),
//          out_valid/out_ready/state_out (output side); master drives inputs, slave is the round unit
interface inv_round_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    modport master (
        output in_valid, state_in, round_key, last_round, out_ready,
        input  in_ready, out_valid, state_out
    );
    modport slave (
        input  in_valid, state_in, round_key, last_round, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/inv_round_unit.sv
// inv_round_unit: AES decryption round core, AddRoundKey -> InvMixColumns (skipped on last round) -> InvShiftRows
// Ports: clk, rst (async, active high), bus (inv_round_if.slave): in_valid/in_ready/state_in/round_key/last_round,
//        out_valid/out_ready/state_out
// Build option: INV_ROUND_FASTMIX_EN mixes two columns per clock instead of one
module inv_round_unit (
    input logic        clk,
    input logic        rst,
    inv_round_if.slave bus
);
`ifdef INV_ROUND_FASTMIX_EN
    localparam logic [1:0] STEP = 2'd2;
`else
    localparam logic [1:0] STEP = 2'd1;
`endif
    localparam logic [1:0] LAST_COL = 2'd0 - STEP;
    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
    state_t       state, state_nxt;
    logic [1:0]   col;
    logic [127:0] work, mixed, shifted;
    logic         in_ready, out_valid, accept;
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
    endfunction
    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction
    // replace the column(s) selected by col; the rest pass through unchanged
    always_comb begin
        mixed = work;
        for (int i = 0; i < 4; i++)
            if (2'(i) == col || (STEP == 2'd2 && 2'(i) == col + 2'd1))
                mixed[127-32*i -: 32] = inv_mix_col(work[127-32*i -: 32]);
    end
    // row r rotated right by r: output column c takes row r from column c-r
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shifted[127-8*(4*c+r) -: 8] = work[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    always_comb
        state_nxt = state == IDLE ? (bus.in_valid ? (bus.last_round ? DONE : MIX) : IDLE)
                  : state == MIX  ? (col == LAST_COL ? DONE : MIX)
                  :                 (bus.out_ready ? IDLE : DONE);
    always_comb begin
        in_ready  = state == IDLE && !rst;
        out_valid = state == DONE;
        accept    = bus.in_valid && in_ready;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            work <= '0;
            col  <= '0;
        end else if (accept) begin
            work <= bus.state_in ^ bus.round_key;
            col  <= '0;
        end else if (state == MIX) begin
            work <= mixed;
            col  <= col + STEP;
        end
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.state_out = shifted;
endmodule

// File: tb/tb_inv_round_unit.sv
// tb_inv_round_unit: randomized and directed check of inv_round_unit against a byte-level AES reference model
module tb_inv_round_unit;
`ifdef INV_ROUND_FASTMIX_EN
    localparam int MIX_LAT = 3;
`else
    localparam int MIX_LAT = 5;
`endif
    localparam logic [127:0] V28_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] V28_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] V29_IN  = 128'h9cac1f73f69f1efb328f48ae45352f18;
    localparam logic [127:0] V30_IN  = {4{32'h8e4da1bc}};
    localparam logic [127:0] V30_OUT = {4{32'hdb135345}};
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail  = 0;
    int or_mode = 1;
    inv_round_if bus();
    inv_round_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic l);
        logic [7:0]   x[16];
        logic [7:0]   y[16];
        logic [7:0]   acc;
        logic [31:0]  cw;
        logic [127:0] o;
        cw = 32'h0e0b0d09;
        for (int b = 0; b < 16; b++) x[b] = s[127-8*b -: 8] ^ k[127-8*b -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc ^= gm(x[4*c+j], cw[31-8*((j-r+4)%4) -: 8]);
                y[4*c+r] = l ? x[4*c+r] : acc;
            end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = y[4*((c-r+4)%4)+r];
        return o;
    endfunction
    // reference: a block accepted at cycle n shows its result from cycle n+latency until taken
    int           cyc = 0;
    int           m_at = 0;
    bit           m_busy = 0;
    logic [127:0] m_exp = '0;
    bit           e_ir, e_ov;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
            chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
            chk("rst_state_out", bus.state_out, 128'(0));
            m_busy = 0;
        end else begin
            e_ir = !m_busy;
            e_ov = m_busy && cyc >= m_at;
            chk("in_ready", 128'(bus.in_ready), 128'(e_ir));
            chk("out_valid", 128'(bus.out_valid), 128'(e_ov));
            if (e_ov) chk("state_out", bus.state_out, m_exp);
            if (bus.in_valid && e_ir) begin
                m_busy = 1;
                m_at   = cyc + (bus.last_round ? 1 : MIX_LAT);
                m_exp  = ref_round(bus.state_in, bus.round_key, bus.last_round);
            end else if (e_ov && bus.out_ready)
                m_busy = 0;
        end
    end
    initial forever begin
        @(posedge clk);
        #1 bus.out_ready = or_mode == 0 ? 1'($urandom_range(0, 1)) : or_mode == 1;
    end
    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l);
        int i;
        bus.state_in   = s;
        bus.round_key  = k;
        bus.last_round = l;
        bus.in_valid   = 1'b1;
        i = 0;
        do @(negedge clk); while (!bus.in_ready && ++i < 100);
        if (i >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for 100 cycles");
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.state_in   = {4{$urandom}};
        bus.round_key  = {4{$urandom}};
        bus.last_round = 1'($urandom_range(0, 1));
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        int k;
        bus.in_valid   = 1'b0;
        bus.state_in   = '0;
        bus.round_key  = '0;
        bus.last_round = 1'b0;
        bus.out_ready  = 1'b1;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int k;
        chk("model_v28", ref_round(V28_IN, '0, 1'b1), V28_OUT);
        chk("model_v29", ref_round(V29_IN, '1, 1'b1), V28_OUT);
        chk("model_v30", ref_round(V30_IN, '0, 1'b0), V30_OUT);
        tick(3);
        rst = 1'b0;
        tick(1);
        or_mode = 2;
        send(V30_IN, '0, 1'b0);
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.out_valid && k < 10);
        chk("v30_latency", 128'(k), 128'(MIX_LAT));
        chk("v30_result", bus.state_out, V30_OUT);
        or_mode = 1;
        tick(2);
        send(V29_IN, '1, 1'b1);
        @(negedge clk);
        chk("v29_result", bus.state_out, V28_OUT);
        tick(2);
        or_mode = 2;
        send(V28_IN, '0, 1'b1);
        repeat (10) begin
            @(posedge clk);
            #1 bus.in_valid = 1'($urandom_range(0, 1));
            bus.state_in   = {4{$urandom}};
            bus.round_key  = {4{$urandom}};
            bus.last_round = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("hold_result", bus.state_out, V28_OUT);
        chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        or_mode = 1;
        tick(3);
        send(V30_IN, '0, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        send(V28_IN, '0, 1'b1);
        tick(3);
        send(V30_IN, '0, 1'b0);
        send(V28_IN, '0, 1'b1);
        tick(3);
        or_mode = 0;
        repeat (200) begin
            send({4{$urandom}}, {4{$urandom}}, $urandom_range(0, 3) == 0);
            tick($urandom_range(0, 2));
        end
        or_mode = 1;
        tick(12);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_round_unit.md
INV_ROUND_UNIT -- requirements
Module: inv_round_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers state_in, round_key and last_round.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 state_in  input  128  ciphertext-side AES state; byte 0 = [127:120], column c = bytes 4c..4c+3, row r = byte 4c+r.
REQ-007 round_key  input  128  round key, same byte order.
REQ-008 last_round  input  1  1 = skip InvMixColumns (final decryption round).
REQ-009 out_valid  output  1  state_out holds a result.
REQ-010 out_ready  input  1  downstream takes the result.
REQ-011 state_out  output  128  InvShiftRows(InvMixColumns(state_in ^ round_key)), or InvShiftRows(state_in ^ round_key) when last_round = 1; feeds InvSubBytes.

Function
REQ-012 States SHALL be IDLE, MIX and DONE; in_ready = 1 only in IDLE with rst low.
REQ-013 Accept edge E0 (in_valid & in_ready) SHALL load work <= state_in ^ round_key and latch last_round; round_key and last_round are not sampled at any other edge.
REQ-014 On E0 with last_round = 1, the block SHALL go to DONE, so out_valid is high directly after E0.
REQ-015 On E0 with last_round = 0, the block SHALL go to MIX with column counter = 0.
REQ-016 In MIX, each edge SHALL replace one column with InvMixColumns of that column (GF(2^8), polynomial 0x11B, coefficients 0e 0b 0d 09), in column order 0,1,2,3.
REQ-017 After column 3 (edge E4), the block SHALL enter DONE with out_valid = 1.
REQ-018 state_out SHALL equal InvShiftRows(work), with row r rotated right by r byte positions. The value is registered or derived combinationally from work, and is stable while out_valid = 1.
REQ-019 In DONE, out_valid SHALL stay 1 and work SHALL stay frozen until out_ready = 1 at an edge. At that edge the block returns to IDLE, so in_ready = 1 in the following cycle; there is no input/output overlap.
REQ-020 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-021 If in_valid and out_ready are both high in DONE, only the output handshake SHALL complete.

Reset
REQ-022 While rst = 1, the block SHALL hold: state IDLE, column counter 0, work 0, out_valid 0, in_ready 0, state_out 0.
REQ-023 Reset asserted mid-MIX or mid-DONE SHALL discard the block in flight immediately, with no partial output.
REQ-024 After rst deasserts, in_ready SHALL be 1 from the first cycle.

Configuration
REQ-025 Macro INV_ROUND_FASTMIX_EN defined: MIX SHALL process two columns per edge (0-1, then 2-3), so out_valid rises at E2.
REQ-026 Macro undefined: one column per edge, so out_valid rises at E4.
REQ-027 Results and last_round latency SHALL be identical in both builds.

Verification
REQ-028 last_round = 1, round_key = 0, state_in = 6353e08c0960e104cd70b751bacad0e7 -> out_valid right after E0; state_out = 63cab7040953d051cd60e0e7ba70e18c.
REQ-029 last_round = 1, round_key = all ff, state_in = 9cac1f73f69f1efb328f48ae45352f18 -> state_out = 63cab7040953d051cd60e0e7ba70e18c.
REQ-030 last_round = 0, round_key = 0, state_in = 8e4da1bc repeated four times -> state_out = db135345 repeated four times. out_valid rises exactly at E4, or at E2 with INV_ROUND_FASTMIX_EN.
REQ-031 Hold out_ready = 0 for 10 cycles after out_valid while toggling in_valid with new data -> state_out, out_valid = 1 and in_ready = 0 unchanged; raise out_ready -> in_ready = 1 next cycle.
REQ-032 Assert rst during the second MIX edge, then release and send the REQ-028 vector -> out_valid = 0 and state_out = 0 during reset; correct REQ-028 result afterward.
REQ-033 Send back-to-back blocks (REQ-030 vector, then REQ-028 vector) with out_ready tied high -> both results correct and in order, with exactly one IDLE cycle between them.
